// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Operand/issue stage for the combinational ALU datapath. Holds
//               a register file, issues registered operands, captures the ALU
//               result after a fixed settle time and writes it back.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ALU_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_op,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              done,
  output logic [DATA_W-1:0] done_data,
  output logic              err,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [4:0] OP_LAST_ALU = 5'h06;
  localparam logic [4:0] OP_LOAD     = 5'h1F;
  localparam logic [4:0] OP_NOP      = 5'h00;
  localparam logic [3:0] WAIT_INIT   = 4'(ALU_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_LOAD = 3'd3,
    S_ERR  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [4:0]        op_q;
  logic [4:0]        rs_q;
  logic [4:0]        rt_q;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;

  // Register 0 is hard-wired to zero on every read path.
  assign rs_val    = (rs_q == 5'd0)     ? '0 : regs[rs_q];
  assign rt_val    = (rt_q == 5'd0)     ? '0 : regs[rt_q];
  assign dbg_data  = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];
  assign cmd_ready = (state == S_IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      op_q      <= 5'd0;
      rs_q      <= 5'd0;
      rt_q      <= 5'd0;
      rd_q      <= 5'd0;
      imm_q     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= OP_NOP;
      done      <= 1'b0;
      done_data <= '0;
      err       <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            rs_q  <= cmd_rs;
            rt_q  <= cmd_rt;
            rd_q  <= cmd_rd;
            imm_q <= cmd_imm;
            if (cmd_op <= OP_LAST_ALU) begin
              state <= S_READ;
            end else if (cmd_op == OP_LOAD) begin
              state <= S_LOAD;
            end else begin
              state <= S_ERR;
            end
          end
        end
        S_READ: begin
          alu_a  <= rs_val;
          alu_b  <= rt_val;
          alu_op <= op_q;
          cnt    <= WAIT_INIT;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          // alu_out is sampled only on the final settle edge.
          if (cnt == 4'd0) begin
            if (rd_q != 5'd0) begin
              regs[rd_q] <= alu_out;
            end
            done_data <= alu_out;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_LOAD: begin
          if (rd_q != 5'd0) begin
            regs[rd_q] <= imm_q;
          end
          done_data <= imm_q;
          done      <= 1'b1;
          state     <= S_DONE;
        end
        S_ERR: begin
          done  <= 1'b1;
          err   <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Operand/issue stage that sits directly upstream of the combinational ALU datapath (5-bit op, 32-bit A/B, 32-bit out). It holds a 32x32 register file and accepts one command at a time over a valid/ready handshake. For each command it drives registered A/B/OP into the ALU, waits a fixed settle time, and writes the ALU result back to the destination register. It gives the ALU chain a clocked source and sink so it can be exercised on hardware.

Parameters:
DATA_W, 32, operand/result width
NUM_REGS, 32, register count (address width 5)
ALU_WAIT, 1, cycles operands are held before result capture (legal 1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  stage can accept a command
cmd_op  in  5  ALU opcode 0x00-0x06, or 0x1F = LOAD immediate
cmd_rs  in  5  source register for A
cmd_rt  in  5  source register for B
cmd_rd  in  5  destination register
cmd_imm  in  32  immediate for LOAD
alu_a  out  32  operand A to ALU (registered)
alu_b  out  32  operand B to ALU (registered)
alu_op  out  5  opcode to ALU (registered)
alu_out  in  32  ALU result
done  out  1  one-cycle pulse at command completion
done_data  out  32  value written (or would have been written) by the last command
err  out  1  one-cycle pulse, coincident with done, for an illegal opcode
dbg_addr  in  5  debug read address
dbg_data  out  32  combinational read of regs[dbg_addr]; reads 0 for address 0

Behaviour:
- Reset (async, rst=1): all registers 0; alu_a/alu_b/done_data=0; alu_op=0x00 (NOP); done=err=0; state IDLE; wait counter 0; cmd_ready=0 while rst is high.
- Reset during any state aborts the command. No write-back occurs.
- cmd_ready = (state==IDLE) and not rst. A command is accepted on an edge with cmd_valid and cmd_ready; op/rs/rt/rd/imm are latched on that edge.
- FSM IDLE -> on accept:
  - op 0x00-0x06 -> READ
  - op 0x1F -> LOAD
  - op 0x07-0x1E -> ERR
- READ (1 cycle): on exit edge, alu_a<=regs[rs], alu_b<=regs[rt], alu_op<=op, cnt<=ALU_WAIT-1; -> WAIT.
- WAIT: each edge decrements cnt. On the edge where cnt==0: regs[rd]<=alu_out (suppressed if rd==0), done_data<=alu_out; -> DONE. alu_out is sampled only on that edge.
- LOAD: on exit edge, regs[rd]<=imm (suppressed if rd==0), done_data<=imm; -> DONE. ALU ports are untouched.
- ERR: on exit edge, no register write; done_data and alu_* unchanged; -> DONE with err flagged.
- DONE (1 cycle): done=1; err=1 only if entered from ERR; cmd_ready=0; -> IDLE.
- Latency for ALU ops, with accept at edge E:
  - operands valid after E+1
  - write at E+1+ALU_WAIT
  - done high the following cycle
  - ready again after E+2+ALU_WAIT
- Latency for LOAD/ERR: done high the cycle after E+1.
- alu_a/alu_b/alu_op hold their last values between commands.
- Register 0 reads as 0 on every path.
- dbg_data shows the old value until the write edge.
- Back-to-back dependent commands need no forwarding: each command completes before the next is accepted.
- cmd_valid while not ready is ignored; the command must be held by the source.
- All arithmetic is the ALU's; this block adds only the 4-bit wait counter, with no wrap.

Test Plan:
- Reset: assert rst mid-stream, then release -> cmd_ready=0 during rst then 1; alu_op=0x00, done=0, dbg_data=0 for all 32 addresses.
- LOAD r1=0x000000FF, LOAD r2=0x00000F0F, then ADD (0x01) rs=1 rt=2 rd=3, bench ALU model returns A+B -> alu_a=0xFF, alu_b=0xF0F, alu_op=0x01 one edge after accept; done pulse with done_data=0x0000100E; dbg_addr=3 reads 0x0000100E.
- LOAD rd=0 imm=0xDEADBEEF -> done pulse, done_data=0xDEADBEEF, dbg_addr=0 still reads 0; ADD rs=0 rt=1 drives alu_a=0.
- Illegal op 0x09 rd=4 -> done and err high together for exactly 1 cycle; r4, alu_a/alu_b/alu_op unchanged; a following legal command executes normally.
- ALU_WAIT=3: accept at edge E; bench changes alu_out at E+2 and E+3 -> value at E+4 is captured; done high in cycle after E+4; cmd_ready=0 from E through done.
- Assert rst during WAIT of ADD to r5 (r5 previously LOADed 0x12345678) -> no done pulse, r5 cleared to 0 by reset, not the ALU value; sequencer accepts a new command after release.
